// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the serial bit-sequence generator.
// The GEN_PARITY_EN build option uses even_parity() to add a parity bit to each frame.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Even parity of up to 64 bits. Narrower callers zero-extend, which leaves the result unchanged.
    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/pattern_shift_reg.sv
// Load/shift register for one frame. The serial output is the MSB.
// A bit-index counter raises final_bit while the last frame bit sits in the MSB.
module pattern_shift_reg #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_val,
    output logic         msb,
    output logic         final_bit
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  sr_q, sr_d;
    logic [IW-1:0] idx_q, idx_d;

    // Next contents: load takes priority over shift, and the index restarts on every load.
    always_comb begin
        sr_d  = sr_q;
        idx_d = idx_q;
        if (load) begin
            sr_d  = load_val;
            idx_d = '0;
        end else if (shift) begin
            sr_d  = {sr_q[W-2:0], 1'b0};
            idx_d = idx_q + IW'(1);
        end
    end

    // Shift register and index flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else begin
            sr_q  <= sr_d;
            idx_q <= idx_d;
        end
    end

    assign msb       = sr_q[W-1];
    assign final_bit = (idx_q == IW'(W - 1));

endmodule

// File: rtl/generate_bit_sequence_using_fsm.sv
// Serialises a latched W-bit pattern MSB-first onto `a`.
// The pattern is sent repeat_count+1 times, with GAP idle cycles between repetitions.
// Build option GEN_PARITY_EN appends an even-parity bit to every frame.
//
// Handshake: start is sampled only on an edge where busy is low. An accepted
// start latches pattern and repeat_count. Starts arriving while busy are
// dropped, not queued. The first bit appears one cycle after acceptance.
// All outputs are registered, one cycle behind the FSM state.
module generate_bit_sequence_using_fsm
    import seq_gen_pkg::*;
#(
    parameter int W     = 6,
    parameter int CNT_W = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     pattern,
    input  logic [CNT_W-1:0] repeat_count,
    output logic             a,
    output logic             a_valid,
    output logic             busy,
    output logic             last,
    output state_t           dbg_state
);

`ifdef GEN_PARITY_EN
    localparam int FRAME_W = W + 1;
`else
    localparam int FRAME_W = W;
`endif
    localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

    // Frame image loaded into the shift register: the pattern, plus the parity bit when enabled.
    function automatic logic [FRAME_W-1:0] frame_of(input logic [W-1:0] p);
`ifdef GEN_PARITY_EN
        return {p, even_parity(64'(p))};
`else
        return p;
`endif
    endfunction

    state_t             state_q, state_d;
    logic [W-1:0]       pat_q, pat_d;
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               a_q, a_d;
    logic               a_valid_q, a_valid_d;
    logic               busy_q, busy_d;
    logic               last_q, last_d;

    logic               sr_load, sr_shift, sr_msb, sr_final;
    logic [FRAME_W-1:0] sr_load_val;

    pattern_shift_reg #(.W(FRAME_W)) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (sr_load),
        .shift     (sr_shift),
        .load_val  (sr_load_val),
        .msb       (sr_msb),
        .final_bit (sr_final)
    );

    // FSM next-state, counter updates and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        rep_d       = rep_q;
        gap_d       = gap_q;
        sr_load     = 1'b0;
        sr_shift    = 1'b0;
        sr_load_val = frame_of(pat_q);
        a_d         = 1'b0;
        a_valid_d   = 1'b0;
        busy_d      = 1'b0;
        last_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !busy_q) begin
                    pat_d       = pattern;
                    rep_d       = repeat_count;
                    sr_load     = 1'b1;
                    sr_load_val = frame_of(pattern);
                    state_d     = SEND;
                end
            end
            SEND: begin
                a_d       = sr_msb;
                a_valid_d = 1'b1;
                busy_d    = 1'b1;
                if (!sr_final) begin
                    sr_shift = 1'b1;
                end else if (rep_q != '0) begin
                    // Count down the remaining repetitions. The count stops at zero, so it never wraps.
                    rep_d   = rep_q - CNT_W'(1);
                    sr_load = 1'b1;
                    if (GAP > 0) begin
                        gap_d   = GAP_W'(GAP_M1);
                        state_d = seq_gen_pkg::GAP;
                    end else begin
                        state_d = SEND;
                    end
                end else begin
                    last_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            seq_gen_pkg::GAP: begin
                busy_d = 1'b1;
                if (gap_q == '0) begin
                    state_d = SEND;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            a_q       <= 1'b0;
            a_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            rep_q     <= rep_d;
            gap_q     <= gap_d;
            a_q       <= a_d;
            a_valid_q <= a_valid_d;
            busy_q    <= busy_d;
            last_q    <= last_d;
        end
    end

    assign a         = a_q;
    assign a_valid   = a_valid_q;
    assign busy      = busy_q;
    assign last      = last_q;
    assign dbg_state = state_q;

endmodule
